alu_seq: RTL and testbench

//   Handshaked, parametrised successor of the combinational ALU: same opcode map, plus status flags,
//   an error output and iterative multi-cycle MUL/DIV. Sits between decode/register-read and writeback.
//   One operation in flight at a time; the result is held until the consumer takes it.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_iter_muldiv.sv | 75 +++++++
 rtl/alu_seq.sv | 138 +++++++++++++
 tb/tb_alu_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode map, FSM states,
// flag bit positions and a small flag-packing helper.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_MUL = 5'd3,
    OP_MOV = 5'd4,
    OP_DIV = 5'd5,
    OP_AND = 5'd9,
    OP_OR  = 5'd10,
    OP_XOR = 5'd11,
    OP_NOT = 5'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Assemble the {N,Z,C,V} flag nibble in the fixed bit order above.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply / divide datapath shared by MUL and DIV.
// MUL: shift-add, accumulator starts as {0, B}, A is added into the high half.
// DIV: restoring divide, accumulator starts as {0, A}, B is the divisor;
//      remainder lives in the high half, quotient shifts into the low half.
// One step per cycle for WIDTH cycles. 'done' is high during the last step and
// 'res'/'hi_nz' then show the value the accumulator takes at that edge, so the
// owner can capture the final answer in the same cycle.
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             hi_nz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic               busy_q;
  logic               is_div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  // One shift-add or restoring-subtract step computed from the current accumulator.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, opnd_q};
    acc_d   = acc_q;
    if (is_div_q) begin
      // diff[WIDTH] set means the trial subtraction borrowed: restore.
      if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  assign done  = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign res   = acc_d[WIDTH-1:0];
  assign hi_nz = !is_div_q && (|acc_d[2*WIDTH-1:WIDTH]);

  // Operand capture on start, then iterate until the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      is_div_q <= is_div;
      cnt_q    <= '0;
      opnd_q   <= is_div ? b : a;
      acc_q    <= {{WIDTH{1'b0}}, (is_div ? a : b)};
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU. One operation in flight; result, flags and err
// are registered and held in DONE until the consumer takes them.
// Handshake: a request is accepted on a rising edge where in_valid && in_ready;
// a result is taken on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE, out_valid only in DONE, so the two never overlap.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [3:0]        alu_flags,
  output logic              err,
  output alu_state_e        state_dbg
);

  alu_state_e       state_q, state_d;
  logic             accept;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_err;
  logic             is_multi, is_div;
  logic [WIDTH:0]   add_full;
  logic             md_done, md_hi_nz;
  logic [WIDTH-1:0] md_res;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             err_q;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign add_full  = {1'b0, src_a} + {1'b0, src_b};
  assign state_dbg = state_q;

  // Single-cycle results and classification of the requested opcode.
  always_comb begin
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_err   = 1'b0;
    is_multi = 1'b0;
    is_div   = 1'b0;
    case (alu_ctrl)
      CTRL_W'(OP_ADD): begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sc_res[WIDTH-1] != src_a[WIDTH-1]);
      end
      CTRL_W'(OP_SUB): begin
        sc_res = src_a - src_b;
        sc_c   = (src_a >= src_b);
        sc_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sc_res[WIDTH-1] != src_a[WIDTH-1]);
      end
      CTRL_W'(OP_MUL): is_multi = 1'b1;
      CTRL_W'(OP_DIV): begin
        is_div = 1'b1;
        if (src_b == '0) begin
          sc_res = '1;
          sc_err = 1'b1;
        end else begin
          is_multi = 1'b1;
        end
      end
      CTRL_W'(OP_MOV): sc_res = src_a;
      CTRL_W'(OP_AND): sc_res = src_a & src_b;
      CTRL_W'(OP_OR):  sc_res = src_a | src_b;
      CTRL_W'(OP_XOR): sc_res = src_a ^ src_b;
      CTRL_W'(OP_NOT): sc_res = ~src_a;
      default:         sc_err = 1'b1;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_multi),
    .is_div(is_div),
    .a     (src_a),
    .b     (src_b),
    .done  (md_done),
    .res   (md_res),
    .hi_nz (md_hi_nz)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: IDLE -> (BUSY ->) DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_multi ? BUSY : DONE;
      BUSY:    if (md_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers: loaded at acceptance for single-cycle ops, at the last
  // iteration for MUL/DIV. err is cleared as soon as a legal op is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (is_multi) begin
        err_q <= 1'b0;
      end else begin
        result_q <= sc_res;
        flags_q  <= pack_flags(sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v);
        err_q    <= sc_err;
      end
    end else if (md_done) begin
      result_q <= md_res;
      flags_q  <= pack_flags(md_res[WIDTH-1], (md_res == '0), md_hi_nz, 1'b0);
      err_q    <= 1'b0;
    end
  end

  assign result    = result_q;
  assign alu_flags = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized operations
// checked against a plain-arithmetic reference model and an expected queue.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [4:0]   alu_ctrl;
  logic [W-1:0] src_a, src_b, result;
  logic [3:0]   alu_flags;
  alu_state_e   state_dbg;

  logic [W+4:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  alu_seq #(.WIDTH(W), .CTRL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .alu_flags(alu_flags), .err(err),
    .state_dbg(state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: result, flags, err and latency from the opcode rules.
  task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [3:0] f, output logic e,
                       output int lat);
    logic [63:0] p;
    logic        c, v;
    longint      ss;
    c = 0; v = 0; e = 0; lat = 1; r = '0;
    case (op)
      5'd1: begin
        p  = {32'b0, a} + {32'b0, b};
        r  = p[31:0]; c = p[32];
        ss = longint'($signed(a)) + longint'($signed(b));
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      5'd2: begin
        r  = a - b; c = (a >= b);
        ss = longint'($signed(a)) - longint'($signed(b));
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      5'd3: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0]; c = (p[63:32] != 0); lat = W + 1;
      end
      5'd4: r = a;
      5'd5: begin
        if (b == 0) begin r = '1; e = 1; end
        else begin r = a / b; lat = W + 1; end
      end
      5'd9:  r = a & b;
      5'd10: r = a | b;
      5'd11: r = a ^ b;
      5'd12: r = ~a;
      default: e = 1;
    endcase
    f = {r[W-1], (r == 0), c, v};
  endtask

  // Driver: issue one op, scramble ports while busy, check the result,
  // hold it for 'hold' cycles under backpressure, then release.
  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold);
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         e;
    int           el, lat, waitc;
    logic [W+4:0] exp;
    model(op, a, b, r, f, e, el);
    exp_q.push_back({e, f, r});
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 50) begin @(negedge clk); waitc++; end
    check("in_ready_idle", in_ready, 1);
    alu_ctrl = op; src_a = a; src_b = b; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; alu_ctrl = 5'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("latency", lat, el);
    exp = exp_q.pop_front();
    check("result", result, exp[W-1:0]);
    check("flags", alu_flags, exp[W+3:W]);
    check("err", err, exp[W+4]);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; alu_ctrl = 5'd1; src_a = $urandom; src_b = $urandom;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", result, exp[W-1:0]);
      check("hold_flags", alu_flags, exp[W+3:W]);
    end
    // Leave DONE with in_valid still high: must not be accepted that edge.
    in_valid = 1; alu_ctrl = 5'd4; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    check("leave_valid", out_valid, 0);
    check("leave_in_ready", in_ready, 1);
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] edges[5];
    edges[0] = 0; edges[1] = 1; edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF;
    case ($urandom_range(0, 3))
      0:       return edges[$urandom_range(0, 4)];
      1:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] ops[13];
    ops = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd12, 5'd0, 5'd6, 5'd13, 5'd31};
    rst_n = 0; in_valid = 0; out_ready = 0; alu_ctrl = 0; src_a = 0; src_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", alu_flags, 0);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, IDLE);
    @(negedge clk); rst_n = 1;

    // directed cases
    do_op(5'd1, 1, 5, 0);
    do_op(5'd2, 2, 1, 0);
    do_op(5'd3, 2, 8, 0);
    do_op(5'd3, 32'h8000_0000, 2, 0);
    do_op(5'd5, 16, 4, 0);
    do_op(5'd5, 7, 0, 0);
    do_op(5'd9, 1, 1, 0);
    do_op(5'd6, 3, 3, 0);
    do_op(5'd1, 32'h7FFF_FFFF, 1, 0);
    do_op(5'd11, 0, 1, 10);
    do_op(5'd3, 32'h1234_5678, 32'h9ABC_DEF0, 2);
    do_op(5'd5, 32'hFFFF_FFFF, 3, 1);

    // reset in the middle of a MUL
    @(negedge clk);
    alu_ctrl = 5'd3; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_1234; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_flags", alu_flags, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk); rst_n = 1;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) check("aborted_no_output", out_valid, 0);
    end
    do_op(5'd12, 0, 0, 0);

    // randomized
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] a, b;
      a = rnd_val(); b = rnd_val();
      do_op(ops[$urandom_range(0, 12)], a, b, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
